// File: rtl/alu_writeback.sv
// alu_writeback: commit stage behind the ALU.
// Writes W or the file bank, tracks flags, counts retired ops.
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [3:0]        inst,
  input  logic              dest,
  input  logic [AW-1:0]     faddr,
  input  logic [DATA_W:0]   ans,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] f,
  output logic [DATA_W-1:0] w,
  output logic [2:0]        status,
  output logic [15:0]       retired,
  output logic              wb_ack,
  output logic              illegal
);

  localparam int NREG = 2**AW;

  logic [DATA_W-1:0] rf [NREG];
  logic              legal;
  logic              wr;
  logic              upd_zn;
  logic              upd_c;
  logic [DATA_W-1:0] v;
  logic              c_q;
  logic              z_q;
  logic              n_q;

  always_comb begin
    legal  = 1'b0;
    wr     = 1'b0;
    upd_zn = 1'b0;
    upd_c  = 1'b0;
    unique case (inst)
      4'd1: begin
        legal = 1'b1;
        wr    = 1'b1;
      end
      4'd2, 4'd3: begin
        legal  = 1'b1;
        wr     = 1'b1;
        upd_zn = 1'b1;
        upd_c  = 1'b1;
      end
      4'd8: legal = 1'b1;
      4'd0, 4'd4, 4'd5, 4'd6,
      4'd7, 4'd9, 4'd10: begin
        legal  = 1'b1;
        wr     = 1'b1;
        upd_zn = 1'b1;
      end
      default: ;
    endcase
  end

  // clear forces zero, so Z=1/N=0 fall out of the normal flag path
  assign v = (inst == 4'd9) ? '0 : ans[DATA_W-1:0];

  assign f      = rf[raddr];
  assign status = {n_q, z_q, c_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w       <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      retired <= '0;
      wb_ack  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NREG; i++)
        rf[i] <= '0;
    end else begin
      wb_ack <= wb_valid & legal;
      if (wb_valid) begin
        if (!legal) begin
          illegal <= 1'b1;
        end else begin
          retired <= retired + 16'd1;
          if (wr) begin
            if (dest)
              rf[faddr] <= v;
            else
              w <= v;
          end
          if (upd_zn) begin
            z_q <= (v == '0);
            n_q <= v[DATA_W-1];
          end
          if (upd_c)
            c_q <= ans[DATA_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed vector table, corner sequences
// and randomized commits against a reference model.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [3:0]  inst;
  logic        dest;
  logic [3:0]  faddr;
  logic [16:0] ans;
  logic [3:0]  raddr;
  logic [15:0] f;
  logic [15:0] w;
  logic [2:0]  status;
  logic [15:0] retired;
  logic        wb_ack;
  logic        illegal;

  alu_writeback #(.DATA_W(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid),
    .inst(inst), .dest(dest), .faddr(faddr), .ans(ans),
    .raddr(raddr), .f(f), .w(w), .status(status),
    .retired(retired), .wb_ack(wb_ack), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference state
  logic [15:0] m_w;
  logic [15:0] m_rf [16];
  logic [15:0] m_ret;
  logic        m_c, m_z, m_n, m_ack, m_ill;

  typedef struct {
    logic        valid;
    logic [3:0]  inst;
    logic        dest;
    logic [3:0]  fa;
    logic [16:0] ans;
    logic [3:0]  ra;
    logic [15:0] ew;
    logic [15:0] ef;
    logic [2:0]  es;
    logic [15:0] er;
    logic        ea;
    logic        ei;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(
    logic vl, logic [3:0] op, logic d, logic [3:0] fa,
    logic [16:0] a, logic [3:0] ra, logic [15:0] ew,
    logic [15:0] ef, logic [2:0] es, logic [15:0] er,
    logic ea, logic ei);
    vec_t t;
    t.valid = vl; t.inst = op; t.dest = d; t.fa = fa;
    t.ans = a; t.ra = ra; t.ew = ew; t.ef = ef;
    t.es = es; t.er = er; t.ea = ea; t.ei = ei;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_w = '0; m_ret = '0;
    m_c = 0; m_z = 0; m_n = 0; m_ack = 0; m_ill = 0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
  endtask

  task automatic model_commit(logic vl, logic [3:0] op, logic d,
                              logic [3:0] fa, logic [16:0] a);
    logic [15:0] val;
    m_ack = 0;
    if (!vl) return;
    if (op > 4'd10) begin
      m_ill = 1;
      return;
    end
    m_ack = 1;
    m_ret = m_ret + 16'd1;
    if (op == 4'd8) return;
    val = (op == 4'd9) ? 16'h0 : a[15:0];
    if (d) m_rf[fa] = val;
    else m_w = val;
    if (op != 4'd1) begin
      m_z = (val == 16'h0);
      m_n = val[15];
    end
    if (op == 4'd2 || op == 4'd3) m_c = a[16];
  endtask

  task automatic check_all(string tag);
    chk({tag, ".w"}, 32'(w), 32'(m_w));
    chk({tag, ".f"}, 32'(f), 32'(m_rf[raddr]));
    chk({tag, ".status"}, 32'(status), 32'({m_n, m_z, m_c}));
    chk({tag, ".retired"}, 32'(retired), 32'(m_ret));
    chk({tag, ".wb_ack"}, 32'(wb_ack), 32'(m_ack));
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_ill));
  endtask

  task automatic drive(logic vl, logic [3:0] op, logic d,
                       logic [3:0] fa, logic [16:0] a, logic [3:0] ra);
    @(negedge clk);
    wb_valid = vl; inst = op; dest = d;
    faddr = fa; ans = a; raddr = ra;
  endtask

  // model-checked commit, including the pre-edge (no bypass) read
  task automatic step(string tag, logic vl, logic [3:0] op, logic d,
                      logic [3:0] fa, logic [16:0] a, logic [3:0] ra);
    drive(vl, op, d, fa, a, ra);
    #1 chk({tag, ".f_pre"}, 32'(f), 32'(m_rf[ra]));
    @(posedge clk);
    model_commit(vl, op, d, fa, a);
    #1 check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; wb_valid = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
  endtask

  initial begin
    reset = 1; wb_valid = 0; inst = 0; dest = 0;
    faddr = 0; ans = 0; raddr = 0;
    model_reset();
    #1 check_all("reset");
    @(negedge clk);
    reset = 0;

    tbl[0]  = mk(1, 2, 0, 0, 17'h10000, 0, 16'h0000, 16'h0000, 3'b011, 1, 1, 0);
    tbl[1]  = mk(1, 5, 1, 3, 17'h08001, 3, 16'h0000, 16'h8001, 3'b101, 2, 1, 0);
    tbl[2]  = mk(1, 3, 0, 0, 17'h000FF, 3, 16'h00FF, 16'h8001, 3'b000, 3, 1, 0);
    tbl[3]  = mk(1, 9, 0, 0, 17'h01234, 3, 16'h0000, 16'h8001, 3'b010, 4, 1, 0);
    tbl[4]  = mk(0, 2, 0, 0, 17'h1FFFF, 0, 16'h0000, 16'h0000, 3'b010, 4, 0, 0);
    tbl[5]  = mk(1, 8, 0, 0, 17'h1FFFF, 3, 16'h0000, 16'h8001, 3'b010, 5, 1, 0);
    tbl[6]  = mk(1, 13, 0, 0, 17'h1FFFF, 3, 16'h0000, 16'h8001, 3'b010, 5, 0, 1);
    tbl[7]  = mk(1, 1, 1, 7, 17'h1ABCD, 7, 16'h0000, 16'hABCD, 3'b010, 6, 1, 1);
    tbl[8]  = mk(1, 4, 0, 0, 17'h10000, 7, 16'h0000, 16'hABCD, 3'b010, 7, 1, 1);
    tbl[9]  = mk(1, 2, 1, 3, 17'h0FFFF, 3, 16'h0000, 16'hFFFF, 3'b100, 8, 1, 1);
    tbl[10] = mk(1, 15, 1, 3, 17'h00000, 3, 16'h0000, 16'hFFFF, 3'b100, 8, 0, 1);
    tbl[11] = mk(1, 10, 0, 0, 17'h17FFF, 7, 16'h7FFF, 16'hABCD, 3'b000, 9, 1, 1);

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].valid, tbl[i].inst, tbl[i].dest,
            tbl[i].fa, tbl[i].ans, tbl[i].ra);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.w", i), 32'(w), 32'(tbl[i].ew));
      chk($sformatf("vec%0d.f", i), 32'(f), 32'(tbl[i].ef));
      chk($sformatf("vec%0d.status", i), 32'(status), 32'(tbl[i].es));
      chk($sformatf("vec%0d.retired", i), 32'(retired), 32'(tbl[i].er));
      chk($sformatf("vec%0d.wb_ack", i), 32'(wb_ack), 32'(tbl[i].ea));
      chk($sformatf("vec%0d.illegal", i), 32'(illegal), 32'(tbl[i].ei));
    end

    // illegal stays set across further legal commits
    for (int i = 0; i < 10; i++) begin
      drive(1, 8, 0, 0, 17'h0, 0);
      @(posedge clk);
      #1;
      chk("sticky.illegal", 32'(illegal), 32'd1);
      chk("sticky.retired", 32'(retired), 32'(10 + i));
    end

    // no bypass: same-cycle read of a pending write sees old data
    do_reset();
    step("bypass0", 1, 0, 1, 5, 17'h01111, 5);
    step("bypass1", 1, 6, 1, 5, 17'h02222, 5);

    // randomized commits
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 1'($urandom),
           4'($urandom), 17'($urandom), 4'($urandom));
    end

    // retired wraps at 0xFFFF without other side effects
    do_reset();
    step("wrap_pre", 1, 2, 0, 0, 17'h18000, 0);
    step("wrap_pre", 1, 3, 1, 9, 17'h04321, 9);
    drive(1, 8, 1, 9, 17'h00000, 9);
    repeat (int'(16'hFFFF - m_ret)) @(posedge clk);
    m_ret = 16'hFFFF;
    m_ack = 1;
    #1 check_all("wrap_full");
    step("wrap", 1, 8, 1, 9, 17'h00000, 9);

    // asynchronous reset mid-cycle with a commit pending
    step("arst_pre", 1, 2, 0, 0, 17'h05555, 6);
    step("arst_pre", 1, 2, 1, 6, 17'h1AAAA, 6);
    drive(1, 2, 0, 0, 17'h13333, 6);
    #2 reset = 1;
    model_reset();
    #1 check_all("arst_now");
    @(negedge clk);
    wb_valid = 0;
    @(posedge clk);
    #2 reset = 0;
    @(posedge clk);
    @(posedge clk);
    #1 check_all("arst_after");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the ALU.
- Captures the 17-bit ALU result and commits it to the W register or to a file-register bank, selected by a destination bit.
- Updates the status flags and counts retired instructions.
- Provides the W and f operands back to the ALU, closing the datapath loop.

Parameters:
DATA_W, 16, operand width; the ALU result is DATA_W+1 bits, with the MSB as carry/borrow.
AW, 4, file-register address width; the bank holds 2**AW entries.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
wb_valid  input  1  ALU result valid this cycle; commit happens at the next rising edge.
inst  input  4  opcode that produced ans; same encoding the ALU uses.
dest  input  1  0 = write W, 1 = write file[faddr].
faddr  input  AW  destination file address.
ans  input  DATA_W+1  ALU result; bit DATA_W is carry/borrow.
raddr  input  AW  file read address for the ALU f operand.
f  output  DATA_W  combinational read of file[raddr], showing pre-edge contents.
w  output  DATA_W  current W register.
status  output  3  {N, Z, C}: bit0 = C, bit1 = Z, bit2 = N.
retired  output  16  count of committed legal instructions.
wb_ack  output  1  registered one-cycle pulse, high the cycle after a legal commit.
illegal  output  1  sticky flag, set by an opcode in 11..15.

Behaviour:
- Reset (asynchronous, immediate):
  - w = 0, status = 0, retired = 0, wb_ack = 0, illegal = 0.
  - All file entries = 0.
  - Reset mid-operation discards any pending commit.
- Commit: at a rising edge with wb_valid = 1, the opcode class is decided by inst. A commit with wb_valid = 0 changes nothing except wb_ack, which goes to 0.
- Legal writing opcodes (0-7, 9, 10):
  - Write ans[DATA_W-1:0] to W when dest = 0, else to file[faddr].
  - Exactly one destination is written.
- Opcode 9 (clear): writes 0 to the destination regardless of ans.
- Opcode 8 (nop):
  - No register write and no flag change.
  - retired still increments and wb_ack still pulses.
- Opcodes 11-15:
  - No write, no flag change, retired unchanged, wb_ack stays 0.
  - illegal set to 1 and held until reset.
- Flag updates, all from the written value (v) and ans[DATA_W]:
  - Opcodes 2 (add) and 3 (sub): C = ans[DATA_W], Z = (v == 0), N = v[DATA_W-1]. For sub, C is the raw borrow bit from the ALU, with no inversion.
  - Opcodes 0, 4, 5, 6, 7, 10: Z and N updated; C unchanged. Increment/decrement wrap is reported only through Z.
  - Opcode 9: Z = 1, N = 0, C unchanged.
  - Opcode 1 (move W): no flag change.
- retired: increments by 1 per legal commit (0-10), wrapping from 0xFFFF to 0x0000.
- wb_ack: high exactly one cycle after each legal commit. Back-to-back legal commits hold it high continuously.
- Read/write timing:
  - f and w are combinational from state, so they show the new value in the cycle after the edge.
  - Same-cycle raddr == faddr with a pending write returns the old value; there is no bypass, and the ALU sees the update on the next cycle.
- Latency: ans at edge N is architecturally visible on w/f and status after edge N.
- Register file: 2**AW x DATA_W flops, one write port, one asynchronous read port.

Test Plan:
- Reset, then wb_valid = 1, inst = 2, dest = 0, ans = 0x1_0000 -> w = 0x0000, status = 3'b011 (Z = 1, C = 1), retired = 1, wb_ack = 1 the next cycle.
- inst = 5, dest = 1, faddr = 3, ans = 0x0_8001; then raddr = 3 -> f = 0x8001, N = 1, Z = 0, C unchanged from the prior op, w unchanged.
- inst = 9, dest = 0 with ans = 0x0_1234 and W preloaded to 0x00FF -> w = 0x0000, Z = 1, N = 0, C held.
- inst = 8, then inst = 13, each with wb_valid = 1:
  - nop: retired +1, wb_ack pulses, no state change.
  - inst 13: illegal = 1, retired unchanged, wb_ack = 0, illegal stays 1 over 10 further legal commits.
- Preload retired to 0xFFFF (via 65535 nops), commit one more -> retired = 0x0000, no other side effects.
- Assert reset asynchronously mid-cycle while wb_valid = 1 with inst = 2 -> outputs clear immediately without waiting for an edge, and no write lands after reset deasserts with wb_valid low.
